// File: rtl/bomber_player_ctrl_if.sv
// Bomb placement request channel between the player controller and the bomb engine.
interface bomber_player_ctrl_if #(
    parameter int unsigned CW = 4,
    parameter int unsigned PW = 2
);
    logic          bomb_req_valid;
    logic          bomb_req_ready;
    logic [CW-1:0] bomb_req_x;
    logic [CW-1:0] bomb_req_y;
    logic [PW-1:0] bomb_req_player;

    modport master (
        output bomb_req_valid, bomb_req_x, bomb_req_y, bomb_req_player,
        input  bomb_req_ready
    );

    modport slave (
        input  bomb_req_valid, bomb_req_x, bomb_req_y, bomb_req_player,
        output bomb_req_ready
    );
endinterface

// File: rtl/bomber_player_ctrl.sv
// Per-player movement and bomb-placement controller for the arena game core.
// Optional: define PLAYER_COLLISION_EN to make players block each other's moves.
module bomber_player_ctrl #(
    parameter int unsigned GRID_W        = 10,
    parameter int unsigned GRID_H        = 10,
    parameter int unsigned NUM_PLAYERS   = 2,
    parameter int unsigned MOVE_COOLDOWN = 2,
    parameter int unsigned MAX_BOMBS     = 1,
    localparam int unsigned CW = 4,
    localparam int unsigned PW = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tick,
    input  logic [3*NUM_PLAYERS-1:0]      cmd,
    input  logic [GRID_W*GRID_H-1:0]      wall_map,
    input  logic [GRID_W*GRID_H-1:0]      bomb_map,
    input  logic [NUM_PLAYERS-1:0]        bomb_done,
    output logic [CW*NUM_PLAYERS-1:0]     pos_x,
    output logic [CW*NUM_PLAYERS-1:0]     pos_y,
    bomber_player_ctrl_if.master          bomb_req,
    output logic [3*NUM_PLAYERS-1:0]      live_bombs
);

    localparam int unsigned CELLS = GRID_W * GRID_H;
    localparam int unsigned IW    = $clog2(CELLS);
    localparam int unsigned CDW   = 4;
    localparam int unsigned LW    = 3;

    typedef logic [CW-1:0] coord_t;
    typedef enum logic {REQ_IDLE, REQ_BUSY} req_state_e;

    coord_t           px_q [NUM_PLAYERS];
    coord_t           px_d [NUM_PLAYERS];
    coord_t           py_q [NUM_PLAYERS];
    coord_t           py_d [NUM_PLAYERS];
    logic [CDW-1:0]   cd_q [NUM_PLAYERS];
    logic [CDW-1:0]   cd_d [NUM_PLAYERS];
    logic [LW-1:0]    live_q [NUM_PLAYERS];
    logic [LW-1:0]    live_d [NUM_PLAYERS];
    coord_t           pend_x_q [NUM_PLAYERS];
    coord_t           pend_x_d [NUM_PLAYERS];
    coord_t           pend_y_q [NUM_PLAYERS];
    coord_t           pend_y_d [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0] pend_q, pend_d;

    req_state_e       state_q, state_d;
    coord_t           req_x_q, req_x_d, req_y_q, req_y_d;
    logic [PW-1:0]    req_player_q, req_player_d;
    logic [PW-1:0]    ptr_q, ptr_d;

    coord_t           tx [NUM_PLAYERS];
    coord_t           ty [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0] mv_ok, new_bomb, granted, cand;
    logic             hs;
    logic             in_range;
    logic [2:0]       op;
    int unsigned      rank, best_rank;

    function automatic logic [IW-1:0] cell_idx(input coord_t x, input coord_t y);
        return IW'(32'(y) * GRID_W + 32'(x));
    endfunction

    function automatic coord_t rst_x(input int p);
        case (p)
            1, 2:    return CW'(GRID_W - 2);
            default: return CW'(1);
        endcase
    endfunction

    function automatic coord_t rst_y(input int p);
        case (p)
            1, 3:    return CW'(GRID_H - 2);
            default: return CW'(1);
        endcase
    endfunction

    // Next-state: moves, bomb capture, live counts and request arbitration.
    always_comb begin
        px_d         = px_q;
        py_d         = py_q;
        cd_d         = cd_q;
        live_d       = live_q;
        pend_d       = pend_q;
        pend_x_d     = pend_x_q;
        pend_y_d     = pend_y_q;
        state_d      = state_q;
        req_x_d      = req_x_q;
        req_y_d      = req_y_q;
        req_player_d = req_player_q;
        ptr_d        = ptr_q;
        tx           = px_q;
        ty           = py_q;
        mv_ok        = '0;
        new_bomb     = '0;
        granted      = '0;
        cand         = '0;
        in_range     = 1'b0;
        op           = '0;
        rank         = 0;
        best_rank    = NUM_PLAYERS;
        hs           = (state_q == REQ_BUSY) && bomb_req.bomb_req_ready;

        // Players are evaluated in index order so lower indices claim a cell first.
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            op       = cmd[3*p +: 3];
            in_range = 1'b0;
            case (op)
                3'd1: begin in_range = (py_q[p] != '0);                    ty[p] = py_q[p] - CW'(1); end
                3'd2: begin in_range = (32'(py_q[p]) + 32'd1 < GRID_H);    ty[p] = py_q[p] + CW'(1); end
                3'd3: begin in_range = (px_q[p] != '0);                    tx[p] = px_q[p] - CW'(1); end
                3'd4: begin in_range = (32'(px_q[p]) + 32'd1 < GRID_W);    tx[p] = px_q[p] + CW'(1); end
                default: ;
            endcase
            if (in_range && cd_q[p] == '0)
                mv_ok[p] = !wall_map[cell_idx(tx[p], ty[p])] && !bomb_map[cell_idx(tx[p], ty[p])];
`ifdef PLAYER_COLLISION_EN
            for (int q = 0; q < NUM_PLAYERS; q++) begin
                if (q != p && px_q[q] == tx[p] && py_q[q] == ty[p])
                    mv_ok[p] = 1'b0;
                if (q < p && mv_ok[q] && tx[q] == tx[p] && ty[q] == ty[p])
                    mv_ok[p] = 1'b0;
            end
`endif
            if (tick) begin
                if (cd_q[p] != '0)
                    cd_d[p] = cd_q[p] - CDW'(1);
                if (mv_ok[p]) begin
                    px_d[p] = tx[p];
                    py_d[p] = ty[p];
                    cd_d[p] = CDW'(MOVE_COOLDOWN);
                end
                if (op == 3'd5 && !pend_q[p] && !bomb_map[cell_idx(px_q[p], py_q[p])]
                    && 32'(live_q[p]) < MAX_BOMBS) begin
                    new_bomb[p] = 1'b1;
                    pend_d[p]   = 1'b1;
                    pend_x_d[p] = px_q[p];
                    pend_y_d[p] = py_q[p];
                end
            end
        end

        if (hs)
            ptr_d = (32'(req_player_q) + 32'd1 >= NUM_PLAYERS) ? '0 : req_player_q + PW'(1);

        // A handshake and a done pulse for the same player cancel out.
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            granted[p] = hs && (req_player_q == PW'(p));
            if (granted[p])
                pend_d[p] = 1'b0;
            if (granted[p] && !bomb_done[p])
                live_d[p] = live_q[p] + LW'(1);
            else if (!granted[p] && bomb_done[p] && live_q[p] != '0)
                live_d[p] = live_q[p] - LW'(1);
        end

        cand = (pend_q & ~granted) | new_bomb;
        if (state_q == REQ_IDLE || hs) begin
            state_d = REQ_IDLE;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                rank = 32'(p) + NUM_PLAYERS - 32'(ptr_d);
                if (rank >= NUM_PLAYERS)
                    rank = rank - NUM_PLAYERS;
                if (cand[p] && rank < best_rank) begin
                    best_rank    = rank;
                    state_d      = REQ_BUSY;
                    req_x_d      = pend_q[p] ? pend_x_q[p] : px_q[p];
                    req_y_d      = pend_q[p] ? pend_y_q[p] : py_q[p];
                    req_player_d = PW'(p);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                px_q[p]     <= rst_x(p);
                py_q[p]     <= rst_y(p);
                cd_q[p]     <= '0;
                live_q[p]   <= '0;
                pend_x_q[p] <= '0;
                pend_y_q[p] <= '0;
            end
            pend_q       <= '0;
            state_q      <= REQ_IDLE;
            req_x_q      <= '0;
            req_y_q      <= '0;
            req_player_q <= '0;
            ptr_q        <= '0;
        end else begin
            px_q         <= px_d;
            py_q         <= py_d;
            cd_q         <= cd_d;
            live_q       <= live_d;
            pend_x_q     <= pend_x_d;
            pend_y_q     <= pend_y_d;
            pend_q       <= pend_d;
            state_q      <= state_d;
            req_x_q      <= req_x_d;
            req_y_q      <= req_y_d;
            req_player_q <= req_player_d;
            ptr_q        <= ptr_d;
        end
    end

    assign bomb_req.bomb_req_valid  = (state_q == REQ_BUSY);
    assign bomb_req.bomb_req_x      = req_x_q;
    assign bomb_req.bomb_req_y      = req_y_q;
    assign bomb_req.bomb_req_player = req_player_q;

    always_comb begin
        pos_x      = '0;
        pos_y      = '0;
        live_bombs = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            pos_x[CW*p +: CW]     = px_q[p];
            pos_y[CW*p +: CW]     = py_q[p];
            live_bombs[3*p +: 3]  = live_q[p];
        end
    end

endmodule
